bird_flight_ctrl: RTL and testbench

- Sequences the player's bird in the flappy-bird game: game-flow FSM (IDLE/PLAY/OVER), gravity timer, and vertical row register.
- Consumes the one-cycle flap pulse from the key edge-detector and the collision flag from the pipe logic.
- Drives the bird row to the LED-array renderer and game status to the score/display logic.

---
 rtl/bird_flight_ctrl.sv | 98 +++++++++
 tb/tb_bird_flight_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_flight_ctrl.sv
// Game-flow controller for the flappy-bird bird: IDLE/PLAY/OVER sequencing,
// gravity timer and the registered vertical row of the bird.
module bird_flight_ctrl #(
   parameter int ROWS        = 16,
   parameter int TICK_CYCLES = 8,
   parameter int FLAP_RISE   = 2,
   parameter int START_ROW   = 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flap_pulse,
   input  logic                    collide,
   output logic [$clog2(ROWS)-1:0] row_out,
   output logic [ROWS-1:0]         bird_onehot,
   output logic                    playing,
   output logic                    game_over,
   output logic                    grav_tick
);

   localparam int RW = $clog2(ROWS);
   localparam int CW = $clog2(TICK_CYCLES);

   localparam logic [RW-1:0] RowStart  = RW'(START_ROW);
   localparam logic [RW-1:0] RowBottom = RW'(ROWS - 1);
   localparam logic [RW-1:0] Rise      = RW'(FLAP_RISE);
   localparam logic [CW-1:0] CountLast = CW'(TICK_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] count;

   // Collision outranks a flap, and a flap cancels a coinciding gravity step.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         row_out   <= RowStart;
         count     <= '0;
         grav_tick <= 1'b0;
      end else begin
         grav_tick <= 1'b0;
         case (state)
            IDLE: begin
               row_out <= RowStart;
               count   <= '0;
               if (flap_pulse) begin
                  state <= PLAY;
               end
            end
            PLAY: begin
               if (collide) begin
                  state <= OVER;
                  count <= '0;
               end else if (flap_pulse) begin
                  row_out <= (row_out >= Rise) ? row_out - Rise : '0;
                  count   <= '0;
               end else if (count == CountLast) begin
                  count     <= '0;
                  grav_tick <= 1'b1;
                  if (row_out == RowBottom) begin
                     state <= OVER;
                  end else begin
                     row_out <= row_out + 1'b1;
                  end
               end else begin
                  count <= count + 1'b1;
               end
            end
            OVER: begin
               count <= '0;
               if (flap_pulse) begin
                  state   <= IDLE;
                  row_out <= RowStart;
               end
            end
            default: begin
               state   <= IDLE;
               row_out <= RowStart;
               count   <= '0;
            end
         endcase
      end
   end

   // State is a register, so these decodes change only on a clock edge.
   assign playing   = (state == PLAY);
   assign game_over = (state == OVER);

   always_comb begin
      bird_onehot          = '0;
      bird_onehot[row_out] = 1'b1;
   end

endmodule

// File: tb/tb_bird_flight_ctrl.sv
// Randomized and directed bench for bird_flight_ctrl; a deadline-based game
// model predicts row, status and gravity strobes every cycle.
module tb_bird_flight_ctrl;

   localparam int ROWS  = 16;
   localparam int TICK  = 4;
   localparam int RISE  = 2;
   localparam int START = 7;

   localparam int M_IDLE = 0;
   localparam int M_PLAY = 1;
   localparam int M_OVER = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic            flap_pulse;
   logic            collide;
   logic [3:0]      row_out;
   logic [ROWS-1:0] bird_onehot;
   logic            playing;
   logic            game_over;
   logic            grav_tick;

   int checks   = 0;
   int failures = 0;

   int     m_mode;
   int     m_row;
   longint cyc = 0;
   longint m_due;
   bit     m_tick;

   wire [22:0] obs = {row_out, playing, game_over, grav_tick, bird_onehot};

   bird_flight_ctrl #(
      .ROWS(ROWS), .TICK_CYCLES(TICK), .FLAP_RISE(RISE), .START_ROW(START)
   ) dut (
      .clk(clk), .reset(reset), .flap_pulse(flap_pulse), .collide(collide),
      .row_out(row_out), .bird_onehot(bird_onehot), .playing(playing),
      .game_over(game_over), .grav_tick(grav_tick)
   );

   always #5 clk = ~clk;

   // Gravity is modelled as an absolute deadline: it lands TICK edges after
   // the last start, flap or gravity step.
   function automatic void model_clock(input bit f, input bit c, input bit r);
      cyc++;
      m_tick = 1'b0;
      if (r) begin
         m_mode = M_IDLE;
         m_row  = START;
      end else if (m_mode == M_IDLE) begin
         if (f) begin
            m_mode = M_PLAY;
            m_due  = cyc + TICK;
         end
      end else if (m_mode == M_PLAY) begin
         if (c) begin
            m_mode = M_OVER;
         end else if (f) begin
            m_row = (m_row - RISE < 0) ? 0 : m_row - RISE;
            m_due = cyc + TICK;
         end else if (cyc == m_due) begin
            m_tick = 1'b1;
            m_due  = cyc + TICK;
            if (m_row == ROWS - 1) m_mode = M_OVER;
            else m_row = m_row + 1;
         end
      end else begin
         if (f) begin
            m_mode = M_IDLE;
            m_row  = START;
         end
      end
   endfunction

   function automatic logic [22:0] expected_vec();
      logic [ROWS-1:0] oh;
      oh = 16'(1) << m_row;
      return {4'(m_row), m_mode == M_PLAY, m_mode == M_OVER, m_tick, oh};
   endfunction

   task automatic applyStimulus(input bit f, input bit c, input bit r);
      flap_pulse = f;
      collide    = c;
      reset      = r;
      @(posedge clk);
      model_clock(f, c, r);
      #1;
      flap_pulse = 1'b0;
      collide    = 1'b0;
      reset      = 1'b0;
   endtask

   task automatic test_reset();
      applyStimulus(0, 0, 1);
      checks++;
      if (obs !== {4'd7, 1'b0, 1'b0, 1'b0, 16'h0080}) begin
         failures++;
         $display("[TB] FAIL reset_state got=%h exp=%h", obs, {4'd7, 3'b000, 16'h0080});
      end
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1, 0);
         checks++;
         if (obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL idle_collide i=%0d got=%h exp=%h", i, obs, expected_vec());
         end
      end
   endtask

   task automatic test_gravity();
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 0);
      checks++;
      if (playing !== 1'b1 || row_out !== 4'd7) begin
         failures++;
         $display("[TB] FAIL start_flap got playing=%b row=%0d exp playing=1 row=7", playing, row_out);
      end
      for (int i = 0; i < 12; i++) begin
         applyStimulus(0, 0, 0);
         checks++;
         if (obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL gravity i=%0d got=%h exp=%h", i, obs, expected_vec());
         end
      end
      checks++;
      if (row_out !== 4'd10) begin
         failures++;
         $display("[TB] FAIL gravity_row got=%0d exp=10", row_out);
      end
   endtask

   task automatic test_flap_top();
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, 0, 0);
         checks++;
         if (obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL flap_up i=%0d got=%h exp=%h", i, obs, expected_vec());
         end
      end
      checks++;
      if (row_out !== 4'd0) begin
         failures++;
         $display("[TB] FAIL flap_saturate got=%0d exp=0", row_out);
      end
      // Fall to row 2, then flap on the cycle the gravity step would land.
      for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      checks++;
      if (row_out !== 4'd0 || grav_tick !== 1'b0) begin
         failures++;
         $display("[TB] FAIL flap_cancels got row=%0d tick=%b exp row=0 tick=0", row_out, grav_tick);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0);
         checks++;
         if (obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL flap_restart i=%0d got=%h exp=%h", i, obs, expected_vec());
         end
      end
   endtask

   task automatic test_ground();
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 46; i++) begin
         applyStimulus(0, 0, 0);
         checks++;
         if (obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL ground i=%0d got=%h exp=%h", i, obs, expected_vec());
         end
      end
      checks++;
      if (game_over !== 1'b1 || row_out !== 4'd15 || grav_tick !== 1'b0) begin
         failures++;
         $display("[TB] FAIL ground_final got over=%b row=%0d tick=%b exp 1/15/0", game_over, row_out, grav_tick);
      end
   endtask

   task automatic test_collide();
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0);
      applyStimulus(1, 1, 0);
      checks++;
      if (game_over !== 1'b1 || row_out !== 4'd9 || playing !== 1'b0) begin
         failures++;
         $display("[TB] FAIL collide_flap got over=%b row=%0d exp over=1 row=9", game_over, row_out);
      end
      applyStimulus(1, 0, 0);
      checks++;
      if (obs !== {4'd7, 3'b000, 16'h0080}) begin
         failures++;
         $display("[TB] FAIL over_to_idle got=%h exp=%h", obs, {4'd7, 3'b000, 16'h0080});
      end
      applyStimulus(1, 0, 0);
      checks++;
      if (playing !== 1'b1 || row_out !== 4'd7) begin
         failures++;
         $display("[TB] FAIL second_flap got playing=%b row=%0d exp 1/7", playing, row_out);
      end
   endtask

   task automatic test_reset_midplay();
      applyStimulus(0, 0, 1);
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 22; i++) applyStimulus(0, 0, 0);
      checks++;
      if (row_out !== 4'd12) begin
         failures++;
         $display("[TB] FAIL midplay_row got=%0d exp=12", row_out);
      end
      applyStimulus(1, 1, 1);
      checks++;
      if (obs !== {4'd7, 3'b000, 16'h0080}) begin
         failures++;
         $display("[TB] FAIL midplay_reset got=%h exp=%h", obs, {4'd7, 3'b000, 16'h0080});
      end
      applyStimulus(1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0);
         checks++;
         if (obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL restart_timing i=%0d got=%h exp=%h", i, obs, expected_vec());
         end
      end
   endtask

   task automatic test_random();
      bit f, c, r;
      for (int i = 0; i < 600; i++) begin
         f = ($urandom_range(5) == 0);
         c = ($urandom_range(24) == 0);
         r = ($urandom_range(99) == 0);
         applyStimulus(f, c, r);
         checks++;
         if (obs !== expected_vec()) begin
            failures++;
            $display("[TB] FAIL random i=%0d f=%b c=%b r=%b got=%h exp=%h", i, f, c, r, obs, expected_vec());
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      flap_pulse = 1'b0;
      collide    = 1'b0;
      m_mode     = M_IDLE;
      m_row      = START;
      m_due      = 0;
      m_tick     = 1'b0;
      test_reset();
      test_gravity();
      test_flap_top();
      test_ground();
      test_collide();
      test_reset_midplay();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
